// File: rtl/vec_mul_sequencer.sv
// Controller for one matrix-vector job: pop a weight tile, reload the array, stream
// UB addresses, then write each array result to the result SRAM after a fixed latency.
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE   = 10,
  parameter int ARRAY_LATENCY = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] num_vectors,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   done
);

  // S_WPOP is the single pop cycle; fifo_empty is sampled one cycle earlier so the
  // strobe stays a pure state decode.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_WPOP   = 3'd2,
    S_RELOAD = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDRESSSIZE-1:0]   r_num;
  logic [ADDRESSSIZE-1:0]   r_src;
  logic [ADDRESSSIZE-1:0]   r_dst;
  logic [ADDRESSSIZE-1:0]   r_issue_cnt;
  logic [ADDRESSSIZE-1:0]   r_wr_cnt;
  logic [ADDRESSSIZE-1:0]   r_ub_addr;
  logic [ARRAY_LATENCY-1:0] r_vpipe;
  logic                     w_accept;
  logic                     w_last_issue;
  logic                     w_last_write;

  assign w_accept     = (r_state == S_IDLE) && start && !abort;
  assign w_last_issue = (r_issue_cnt == (r_num - ADDRESSSIZE'(1)));
  assign w_last_write = res_write_enable && (r_wr_cnt == (r_num - ADDRESSSIZE'(1)));

  // Next-state selection; abort overrides every state.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!start) begin
            w_next_state = S_IDLE;
          end else if (num_vectors == '0) begin
            w_next_state = S_DONE;
          end else if (!fifo_empty) begin
            w_next_state = S_WPOP;
          end else begin
            w_next_state = S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (!fifo_empty) begin
            w_next_state = S_WPOP;
          end else begin
            w_next_state = S_WLOAD;
          end
        end
        S_WPOP:   w_next_state = S_RELOAD;
        S_RELOAD: w_next_state = S_STREAM;
        S_STREAM: begin
          if (w_last_issue) begin
            w_next_state = S_DRAIN;
          end else begin
            w_next_state = S_STREAM;
          end
        end
        S_DRAIN: begin
          if (w_last_write) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State, job registers, counters and the result-valid pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_ub_addr   <= '0;
      r_vpipe     <= '0;
    end else begin
      r_state <= w_next_state;

      if (abort) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= (r_vpipe << 1'b1) | ARRAY_LATENCY'(r_state == S_STREAM);
      end

      if (w_accept) begin
        r_num       <= num_vectors;
        r_src       <= src_base;
        r_dst       <= dst_base;
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
      end else begin
        if (res_write_enable) begin
          r_wr_cnt <= r_wr_cnt + ADDRESSSIZE'(1);
        end
        if (r_state == S_STREAM) begin
          r_issue_cnt <= r_issue_cnt + ADDRESSSIZE'(1);
        end
      end

      // The UB address holds its final value through DRAIN and DONE.
      if (r_state == S_RELOAD) begin
        r_ub_addr <= r_src;
      end else if ((r_state == S_STREAM) && !w_last_issue) begin
        r_ub_addr <= r_ub_addr + ADDRESSSIZE'(1);
      end
    end
  end

  assign fifo_read_enable = (r_state == S_WPOP);
  assign weight_reload    = (r_state == S_RELOAD);
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign ub_address       = r_ub_addr;
  assign res_write_enable = r_vpipe[ARRAY_LATENCY-1];
  assign res_address      = r_dst + r_wr_cnt;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench: directed job scenarios followed by random traffic, all compared
// cycle by cycle against a job-timeline reference model.
module tb_vec_mul_sequencer;

  localparam int AW = 10;
  localparam int AL = 4;
  localparam int NC = 2000;
  localparam int NA = NC + 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] num_vectors = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          fifo_empty = 1'b0;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic [AW-1:0] ub_address;
  logic          res_write_enable;
  logic [AW-1:0] res_address;
  logic          busy;
  logic          done;

  vec_mul_sequencer #(.ADDRESSSIZE(AW), .ARRAY_LATENCY(AL)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .num_vectors      (num_vectors),
    .src_base         (src_base),
    .dst_base         (dst_base),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .weight_reload    (weight_reload),
    .ub_address       (ub_address),
    .res_write_enable (res_write_enable),
    .res_address      (res_address),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Stimulus per cycle
  bit          st_start[NA];
  bit          st_abort[NA];
  bit          st_rst[NA];
  bit          st_fe[NA];
  bit [AW-1:0] st_n[NA];
  bit [AW-1:0] st_src[NA];
  bit [AW-1:0] st_dst[NA];

  // Expected outputs per cycle
  bit          e_fre[NA];
  bit          e_wr[NA];
  bit          e_busy[NA];
  bit          e_done[NA];
  bit          e_we[NA];
  bit          e_ub_chk[NA];
  bit [AW-1:0] e_ub[NA];
  bit          e_ra_chk[NA];
  bit [AW-1:0] e_ra[NA];
  bit          e_zero[NA];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic put_job(input int c, input int n, input int src, input int dst);
    st_start[c] = 1'b1;
    st_n[c]     = AW'(n);
    st_src[c]   = AW'(src);
    st_dst[c]   = AW'(dst);
  endtask

  task automatic clear_exp(input int k);
    e_fre[k] = 1'b0; e_wr[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
    e_we[k] = 1'b0; e_ub_chk[k] = 1'b0; e_ra_chk[k] = 1'b0;
  endtask

  // Job-level model: each accepted job is laid out as a timeline from its pop cycle,
  // and abort/rst truncate whatever of that timeline lies in the future.
  task automatic build_model();
    int idle_from = 0;
    int job_end   = -1;
    int p, n, done_c;
    for (int c = 0; c < NC; c++) begin
      if (st_rst[c] || st_abort[c]) begin
        if (c < idle_from) begin
          for (int k = c + 1; k <= job_end; k++) clear_exp(k);
          idle_from = c + 1;
        end
        if (st_rst[c]) e_zero[c+1] = 1'b1;
      end else if (st_start[c] && c >= idle_from) begin
        n = int'(st_n[c]);
        if (n == 0) begin
          e_busy[c+1] = 1'b1;
          e_done[c+1] = 1'b1;
          job_end = c + 1;
        end else begin
          p = c + 1;
          while (p < NC && st_fe[p-1]) p++;
          done_c = p + n + AL + 2;
          e_fre[p]   = 1'b1;
          e_wr[p+1]  = 1'b1;
          for (int i = 0; i < n; i++) begin
            e_ub_chk[p+2+i]    = 1'b1;
            e_ub[p+2+i]        = AW'(int'(st_src[c]) + i);
            e_we[p+2+i+AL]     = 1'b1;
            e_ra_chk[p+2+i+AL] = 1'b1;
            e_ra[p+2+i+AL]     = AW'(int'(st_dst[c]) + i);
          end
          for (int k = p + 2 + n; k <= done_c; k++) begin
            e_ub_chk[k] = 1'b1;
            e_ub[k]     = AW'(int'(st_src[c]) + n - 1);
          end
          for (int k = c + 1; k <= done_c; k++) e_busy[k] = 1'b1;
          e_done[done_c] = 1'b1;
          job_end = done_c;
        end
        idle_from = job_end + 1;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NA; c++) begin
      st_start[c] = 1'b0; st_abort[c] = 1'b0; st_rst[c] = 1'b0; st_fe[c] = 1'b0;
      st_n[c] = '0; st_src[c] = '0; st_dst[c] = '0;
      clear_exp(c);
      e_ub[c] = '0; e_ra[c] = '0; e_zero[c] = 1'b0;
    end

    // Directed scenarios
    for (int c = 0; c < 3; c++) st_rst[c] = 1'b1;
    put_job(5, 3, 'h010, 'h020);                  // nominal
    put_job(20, 1, 'h100, 'h200);                 // FIFO stall
    for (int c = 20; c < 25; c++) st_fe[c] = 1'b1;
    put_job(40, 4, 'h3FE, 'h3FF);                 // address wrap
    put_job(55, 0, 'h123, 'h321);                 // zero length
    put_job(60, 8, 'h050, 'h060);                 // abort after second issue
    st_abort[64] = 1'b1;
    put_job(66, 2, 'h070, 'h080);
    put_job(80, 5, 'h0A0, 'h0B0);                 // start while busy is ignored
    put_job(85, 2, 'h001, 'h002);
    put_job(100, 5, 'h0C0, 'h0D0);                // rst during DRAIN
    st_rst[109] = 1'b1;

    // Random traffic
    for (int c = 130; c < NC - 100; c++) begin
      if ($urandom_range(0, 5) == 0)
        put_job(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)));
      st_fe[c]    = ($urandom_range(0, 3) == 0);
      st_abort[c] = ($urandom_range(0, 49) == 0);
      st_rst[c]   = ($urandom_range(0, 199) == 0);
    end

    build_model();

    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      rst         = st_rst[c];
      abort       = st_abort[c];
      start       = st_start[c];
      num_vectors = st_n[c];
      src_base    = st_src[c];
      dst_base    = st_dst[c];
      fifo_empty  = st_fe[c];
      @(negedge clk);
      if (c >= 1) begin
        chk($sformatf("busy@%0d", c), 32'(busy), 32'(e_busy[c]));
        chk($sformatf("done@%0d", c), 32'(done), 32'(e_done[c]));
        chk($sformatf("fifo_read_enable@%0d", c), 32'(fifo_read_enable), 32'(e_fre[c]));
        chk($sformatf("weight_reload@%0d", c), 32'(weight_reload), 32'(e_wr[c]));
        chk($sformatf("res_write_enable@%0d", c), 32'(res_write_enable), 32'(e_we[c]));
        if (e_ub_chk[c]) chk($sformatf("ub_address@%0d", c), 32'(ub_address), 32'(e_ub[c]));
        if (e_ra_chk[c]) chk($sformatf("res_address@%0d", c), 32'(res_address), 32'(e_ra[c]));
        if (e_zero[c]) begin
          chk($sformatf("rst_ub_address@%0d", c), 32'(ub_address), 32'd0);
          chk($sformatf("rst_res_address@%0d", c), 32'(res_address), 32'd0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
